// File: rtl/msp430_per_arbiter2_if.sv
// Requester channel of the two-master peripheral-bus arbiter: one transfer
// request with its grant, single-cycle ack and last read data.
interface msp430_per_arbiter2_if;
    logic        req;
    logic        lock;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic        gnt;
    logic        ack;
    logic [15:0] dout;

    modport master (
        output req, lock, addr, we, din,
        input  gnt, ack, dout
    );

    modport slave (
        input  req, lock, addr, we, din,
        output gnt, ack, dout
    );
endinterface

// File: rtl/msp430_per_arbiter2.sv
// Two-master arbiter for one openMSP430 peripheral bus: registered request
// capture, one BUS cycle per transfer, single-cycle ack, optional locked bursts.
module msp430_per_arbiter2 #(
    parameter bit PRIO_FIXED = 1'b0,
    parameter int MAX_LOCK   = 4
) (
    input  logic                         mclk,
    input  logic                         puc_rst,
    msp430_per_arbiter2_if.slave         m0,
    msp430_per_arbiter2_if.slave         m1,
    output logic                         per_en,
    output logic [13:0]                  per_addr,
    output logic [1:0]                   per_we,
    output logic [15:0]                  per_din,
    input  logic [15:0]                  per_dout
);

    localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

    typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_owner_reg, last_owner_next;
    logic [3:0]  lock_cnt_reg, lock_cnt_next;
    logic [13:0] addr_reg, addr_next;
    logic [1:0]  we_reg, we_next;
    logic [15:0] din_reg, din_next;
    logic [15:0] dout_reg [2];

    logic [1:0]  req;
    logic [1:0]  lock;
    logic [13:0] req_addr [2];
    logic [1:0]  req_we   [2];
    logic [15:0] req_din  [2];
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        sel;
    logic        bus_active;

    assign req         = {m1.req, m0.req};
    assign lock        = {m1.lock, m0.lock};
    assign req_addr[0] = m0.addr;
    assign req_addr[1] = m1.addr;
    assign req_we[0]   = m0.we;
    assign req_we[1]   = m1.we;
    assign req_din[0]  = m0.din;
    assign req_din[1]  = m1.din;

    // On a tie the master that did not own the bus last wins, unless fixed priority.
    assign sel = (req == 2'b11) ? (PRIO_FIXED ? 1'b0 : ~last_owner_reg) : req[1];

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            lock_cnt_reg   <= 4'd0;
            addr_reg       <= '0;
            we_reg         <= '0;
            din_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            din_reg        <= din_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        lock_cnt_next   = lock_cnt_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        din_next        = din_reg;
        unique case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next      = sel;
                    last_owner_next = sel;
                    addr_next       = req_addr[sel];
                    we_next         = req_we[sel];
                    din_next        = req_din[sel];
                    state_next      = BUS;
                end
            end
            BUS: begin
                state_next = ACK;
            end
            ACK: begin
                // Locked continuation skips arbitration entirely, bounded by MAX_LOCK.
                if (lock[owner_reg] && req[owner_reg] && (lock_cnt_reg < LOCK_LAST)) begin
                    addr_next     = req_addr[owner_reg];
                    we_next       = req_we[owner_reg];
                    din_next      = req_din[owner_reg];
                    lock_cnt_next = lock_cnt_reg + 4'd1;
                    state_next    = BUS;
                end else begin
                    lock_cnt_next = 4'd0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus fields are forced to zero outside BUS so the OR-combined bus stays clean.
    assign bus_active = (state_reg == BUS);
    assign per_en     = bus_active;
    assign per_addr   = bus_active ? addr_reg : 14'd0;
    assign per_we     = bus_active ? we_reg   : 2'd0;
    assign per_din    = bus_active ? din_reg  : 16'd0;

    assign gnt = (state_reg != IDLE) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
    assign ack = (state_reg == ACK)  ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dout
            always_ff @(posedge mclk) begin
                if (puc_rst) begin
                    dout_reg[gi] <= 16'h0000;
                end else if (bus_active && (we_reg == 2'b00) && (owner_reg == 1'(gi))) begin
                    dout_reg[gi] <= per_dout;
                end
            end
        end
    endgenerate

    assign m0.gnt  = gnt[0];
    assign m1.gnt  = gnt[1];
    assign m0.ack  = ack[0];
    assign m1.ack  = ack[1];
    assign m0.dout = dout_reg[0];
    assign m1.dout = dout_reg[1];

endmodule

// File: tb/tb_msp430_per_arbiter2.sv
// Scoreboard bench for msp430_per_arbiter2: round-robin instance with a
// peripheral memory model, plus a fixed-priority instance checked by ack order.
module tb_msp430_per_arbiter2;

    typedef struct {
        logic        lock;
        logic [13:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } cmd_t;

    typedef struct {
        int          m;
        logic [13:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
        int          gap;
        int          lat;
    } bus_t;

    typedef struct {
        int          m;
        logic [15:0] d0;
        logic [15:0] d1;
    } ack_t;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        per_en;
    logic [13:0] per_addr;
    logic [1:0]  per_we;
    logic [15:0] per_din;
    logic [15:0] per_dout;
    logic        fx_per_en;
    logic [13:0] fx_per_addr;
    logic [1:0]  fx_per_we;
    logic [15:0] fx_per_din;

    int checks = 0;
    int errors = 0;

    cmd_t cmd_q [4][$];
    bus_t bus_q [$];
    ack_t ack_q [$];
    int   fx_q  [$];

    always #5 mclk = ~mclk;

    msp430_per_arbiter2_if mif [4] ();

    msp430_per_arbiter2 #(.PRIO_FIXED(1'b0), .MAX_LOCK(4)) u_dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .m0       (mif[0]),
        .m1       (mif[1]),
        .per_en   (per_en),
        .per_addr (per_addr),
        .per_we   (per_we),
        .per_din  (per_din),
        .per_dout (per_dout)
    );

    msp430_per_arbiter2 #(.PRIO_FIXED(1'b1), .MAX_LOCK(4)) u_dut_fix (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .m0       (mif[2]),
        .m1       (mif[3]),
        .per_en   (fx_per_en),
        .per_addr (fx_per_addr),
        .per_we   (fx_per_we),
        .per_din  (fx_per_din),
        .per_dout (16'h0000)
    );

    // Peripheral model: 256-word register file, byte-enabled writes, combinational read.
    logic [15:0] mem [256];
    logic        mem_ready = 1'b0;

    always @(posedge mclk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'hC8] <= 16'h1234;
            mem[8'hCB] <= 16'h5678;
            mem_ready  <= 1'b1;
        end else if (per_en) begin
            if (per_we[0]) mem[per_addr[7:0]][7:0]  <= per_din[7:0];
            if (per_we[1]) mem[per_addr[7:0]][15:8] <= per_din[15:8];
        end
    end

    assign per_dout = per_en ? mem[per_addr[7:0]] : 16'h0000;

    assert property (@(negedge mclk) !(mif[0].gnt && mif[1].gnt));

    // Requester drivers: present a command, hold it until ack, chain the next one in the ack cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_drv
            initial begin
                cmd_t c;
                int   n;
                mif[gi].req  = 1'b0;
                mif[gi].lock = 1'b0;
                mif[gi].addr = '0;
                mif[gi].we   = '0;
                mif[gi].din  = '0;
                forever begin
                    @(posedge mclk); #1;
                    if (cmd_q[gi].size() != 0 && !puc_rst) begin
                        c = cmd_q[gi].pop_front();
                        mif[gi].lock = c.lock;
                        mif[gi].addr = c.addr;
                        mif[gi].we   = c.we;
                        mif[gi].din  = c.din;
                        mif[gi].req  = 1'b1;
                        n = 0;
                        forever begin
                            @(posedge mclk); #1;
                            n++;
                            if (puc_rst) begin
                                mif[gi].req  = 1'b0;
                                mif[gi].lock = 1'b0;
                                break;
                            end
                            if (mif[gi].ack) begin
                                if (cmd_q[gi].size() != 0) begin
                                    c = cmd_q[gi].pop_front();
                                    mif[gi].lock = c.lock;
                                    mif[gi].addr = c.addr;
                                    mif[gi].we   = c.we;
                                    mif[gi].din  = c.din;
                                    n = 0;
                                end else begin
                                    mif[gi].req  = 1'b0;
                                    mif[gi].lock = 1'b0;
                                    mif[gi].addr = '0;
                                    mif[gi].we   = '0;
                                    mif[gi].din  = '0;
                                    break;
                                end
                            end else if (n > 200) begin
                                errors++;
                                $display("FAIL ack_timeout: master %0d got no ack within 200 cycles, required an ack", gi);
                                mif[gi].req = 1'b0;
                                break;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Monitor: compares every bus cycle and every ack against the scoreboard queues.
    int   cyc = 0;
    int   last_en_cyc = 0;
    logic prev_en = 1'b0;
    logic prev_own = 1'b0;
    logic prev_req [2] = '{1'b0, 1'b0};
    int   req_rise [2] = '{0, 0};

    initial begin
        bus_t e;
        ack_t a;
        logic g;
        logic r;
        int   am;
        int   fm;
        forever begin
            @(negedge mclk);
            cyc++;
            for (int m = 0; m < 2; m++) begin
                r = (m == 1) ? mif[1].req : mif[0].req;
                if (r && !prev_req[m]) req_rise[m] = cyc;
                prev_req[m] = r;
            end
            checks++;
            if (mif[0].gnt && mif[1].gnt) begin
                errors++;
                $display("FAIL gnt_overlap: m0_gnt=%b m1_gnt=%b, required at most one", mif[0].gnt, mif[1].gnt);
            end
            if (per_en) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_per_en: per_en=1 addr=%h, required per_en=0", per_addr);
                end else begin
                    e = bus_q.pop_front();
                    g = (e.m == 1) ? mif[1].gnt : mif[0].gnt;
                    if (!g || per_addr !== e.addr || per_we !== e.we || per_din !== e.din) begin
                        errors++;
                        $display("FAIL bus_xfer: got gnt%0d=%b addr=%h we=%b din=%h, required gnt%0d=1 addr=%h we=%b din=%h",
                                 e.m, g, per_addr, per_we, per_din, e.m, e.addr, e.we, e.din);
                    end
                    if (e.gap != 0) begin
                        checks++;
                        if (cyc - last_en_cyc != e.gap) begin
                            errors++;
                            $display("FAIL bus_spacing: got %0d cycles between per_en, required %0d", cyc - last_en_cyc, e.gap);
                        end
                    end
                    if (e.lat != 0) begin
                        checks++;
                        if (cyc - req_rise[e.m] != e.lat) begin
                            errors++;
                            $display("FAIL req_latency: got per_en %0d cycles after req, required %0d", cyc - req_rise[e.m], e.lat);
                        end
                    end
                end
                last_en_cyc = cyc;
            end else begin
                checks++;
                if (per_addr !== 14'd0 || per_we !== 2'd0 || per_din !== 16'd0) begin
                    errors++;
                    $display("FAIL bus_idle: got addr=%h we=%b din=%h, required all zero", per_addr, per_we, per_din);
                end
            end
            if (mif[0].ack || mif[1].ack) begin
                am = mif[1].ack ? 1 : 0;
                checks++;
                if (mif[0].ack && mif[1].ack) begin
                    errors++;
                    $display("FAIL ack_overlap: m0_ack=1 m1_ack=1, required a single ack");
                end
                checks++;
                if (!prev_en || prev_own != mif[1].ack) begin
                    errors++;
                    $display("FAIL ack_timing: got ack m%0d with prev per_en=%b owner=%0d, required per_en by same owner one cycle earlier",
                             am, prev_en, prev_own);
                end
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got ack from m%0d, required no ack", am);
                end else begin
                    a = ack_q.pop_front();
                    if (am != a.m || mif[0].dout !== a.d0 || mif[1].dout !== a.d1) begin
                        errors++;
                        $display("FAIL ack_data: got m%0d dout0=%h dout1=%h, required m%0d dout0=%h dout1=%h",
                                 am, mif[0].dout, mif[1].dout, a.m, a.d0, a.d1);
                    end
                end
            end
            prev_en  = per_en;
            prev_own = mif[1].gnt;

            checks++;
            if ((mif[2].gnt && mif[3].gnt) ||
                (!fx_per_en && (fx_per_addr != 14'd0 || fx_per_we != 2'd0 || fx_per_din != 16'd0))) begin
                errors++;
                $display("FAIL fix_bus: got gnt=%b%b per_en=%b addr=%h, required one gnt and zero idle bus",
                         mif[3].gnt, mif[2].gnt, fx_per_en, fx_per_addr);
            end
            if (mif[2].ack || mif[3].ack) begin
                fm = mif[3].ack ? 3 : 2;
                checks++;
                if (fx_q.size() == 0) begin
                    errors++;
                    $display("FAIL fix_unexpected_ack: got ack from master %0d, required none", fm - 2);
                end else if (fx_q[0] != fm) begin
                    errors++;
                    $display("FAIL fix_order: got ack from m%0d, required m%0d", fm - 2, fx_q[0] - 2);
                    void'(fx_q.pop_front());
                end else begin
                    void'(fx_q.pop_front());
                end
            end
        end
    end

    task automatic push_cmd(input int m, input logic lk, input logic [13:0] ad, input logic [1:0] w, input logic [15:0] d);
        cmd_t c;
        c.lock = lk; c.addr = ad; c.we = w; c.din = d;
        cmd_q[m].push_back(c);
    endtask

    task automatic exp_bus(input int m, input logic [13:0] ad, input logic [1:0] w, input logic [15:0] d,
                           input int gap, input int lat);
        bus_t e;
        e.m = m; e.addr = ad; e.we = w; e.din = d; e.gap = gap; e.lat = lat;
        bus_q.push_back(e);
    endtask

    task automatic exp_ack(input int m, input logic [15:0] d0, input logic [15:0] d1);
        ack_t a;
        a.m = m; a.d0 = d0; a.d1 = d1;
        ack_q.push_back(a);
    endtask

    function automatic bit all_done();
        bit done;
        done = (bus_q.size() == 0) && (ack_q.size() == 0) && (fx_q.size() == 0);
        for (int i = 0; i < 4; i++) done = done && (cmd_q[i].size() == 0);
        done = done && !mif[0].req && !mif[1].req && !mif[2].req && !mif[3].req;
        return done;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!all_done() && n < budget);
        checks++;
        if (!all_done()) begin
            errors++;
            $display("FAIL %s_timeout: scoreboard still has bus=%0d ack=%0d fix=%0d entries, required empty",
                     tag, bus_q.size(), ack_q.size(), fx_q.size());
        end
        @(negedge mclk);
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (per_en !== 1'b0 || mif[0].gnt !== 1'b0 || mif[1].gnt !== 1'b0 ||
            mif[0].ack !== 1'b0 || mif[1].ack !== 1'b0 ||
            mif[0].dout !== 16'h0000 || mif[1].dout !== 16'h0000) begin
            errors++;
            $display("FAIL %s: got per_en=%b gnt=%b%b ack=%b%b dout0=%h dout1=%h, required all zero",
                     tag, per_en, mif[1].gnt, mif[0].gnt, mif[1].ack, mif[0].ack, mif[0].dout, mif[1].dout);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge mclk);
        check_quiet("reset_state");
        puc_rst = 1'b0;

        // Single write, then a read-back by the other master.
        push_cmd(0, 1'b0, 14'h00C9, 2'b11, 16'hA5A5);
        exp_bus(0, 14'h00C9, 2'b11, 16'hA5A5, 0, 1);
        exp_ack(0, 16'h0000, 16'h0000);
        wait_idle(50, "m0_write");

        push_cmd(1, 1'b0, 14'h00C9, 2'b00, 16'h0000);
        exp_bus(1, 14'h00C9, 2'b00, 16'h0000, 0, 1);
        exp_ack(1, 16'h0000, 16'hA5A5);
        wait_idle(50, "m1_read");

        // Round-robin with both masters held: m0, m1, m0, m1.
        push_cmd(0, 1'b0, 14'h0010, 2'b11, 16'h1111);
        push_cmd(0, 1'b0, 14'h0012, 2'b11, 16'h3333);
        push_cmd(1, 1'b0, 14'h0011, 2'b11, 16'h2222);
        push_cmd(1, 1'b0, 14'h0013, 2'b11, 16'h4444);
        exp_bus(0, 14'h0010, 2'b11, 16'h1111, 0, 0);
        exp_bus(1, 14'h0011, 2'b11, 16'h2222, 3, 0);
        exp_bus(0, 14'h0012, 2'b11, 16'h3333, 3, 0);
        exp_bus(1, 14'h0013, 2'b11, 16'h4444, 3, 0);
        exp_ack(0, 16'h0000, 16'hA5A5);
        exp_ack(1, 16'h0000, 16'hA5A5);
        exp_ack(0, 16'h0000, 16'hA5A5);
        exp_ack(1, 16'h0000, 16'hA5A5);
        wait_idle(100, "round_robin");

        // Fixed priority instance: m0 wins every tie while it keeps requesting.
        for (int i = 0; i < 4; i++) push_cmd(2, 1'b0, 14'(i), 2'b11, 16'(i));
        push_cmd(3, 1'b0, 14'h0020, 2'b11, 16'h0020);
        for (int i = 0; i < 4; i++) fx_q.push_back(2);
        fx_q.push_back(3);
        wait_idle(100, "fixed_prio");

        // Locked burst saturates after 4 transfers, m1 gets its turn, m0 resumes.
        for (int i = 0; i < 6; i++) push_cmd(0, 1'b1, 14'h0020 + 14'(i), 2'b11, 16'hB000 + 16'(i));
        push_cmd(1, 1'b0, 14'h0030, 2'b11, 16'hC000);
        exp_bus(0, 14'h0020, 2'b11, 16'hB000, 0, 0);
        exp_bus(0, 14'h0021, 2'b11, 16'hB001, 2, 0);
        exp_bus(0, 14'h0022, 2'b11, 16'hB002, 2, 0);
        exp_bus(0, 14'h0023, 2'b11, 16'hB003, 2, 0);
        exp_bus(1, 14'h0030, 2'b11, 16'hC000, 3, 0);
        exp_bus(0, 14'h0024, 2'b11, 16'hB004, 3, 0);
        exp_bus(0, 14'h0025, 2'b11, 16'hB005, 2, 0);
        for (int i = 0; i < 4; i++) exp_ack(0, 16'h0000, 16'hA5A5);
        exp_ack(1, 16'h0000, 16'hA5A5);
        exp_ack(0, 16'h0000, 16'hA5A5);
        exp_ack(0, 16'h0000, 16'hA5A5);
        wait_idle(150, "locked_burst");

        // Reset during the BUS cycle of an m1 write aborts it without ack.
        push_cmd(1, 1'b0, 14'h0040, 2'b11, 16'hBEEF);
        exp_bus(1, 14'h0040, 2'b11, 16'hBEEF, 0, 0);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!(per_en && mif[1].gnt) && n < 20);
        checks++;
        if (!(per_en && mif[1].gnt)) begin
            errors++;
            $display("FAIL abort_setup: got per_en=%b m1_gnt=%b, required both 1", per_en, mif[1].gnt);
        end
        puc_rst = 1'b1;
        @(negedge mclk);
        check_quiet("abort_reset");
        puc_rst = 1'b0;
        @(negedge mclk);
        check_quiet("abort_idle");

        push_cmd(0, 1'b0, 14'h0050, 2'b11, 16'h5050);
        push_cmd(1, 1'b0, 14'h0051, 2'b11, 16'h5151);
        exp_bus(0, 14'h0050, 2'b11, 16'h5050, 0, 0);
        exp_bus(1, 14'h0051, 2'b11, 16'h5151, 3, 0);
        exp_ack(0, 16'h0000, 16'h0000);
        exp_ack(1, 16'h0000, 16'h0000);
        wait_idle(50, "post_reset_tie");

        // Interleaved reads and a byte write: each dout tracks only its own reads.
        push_cmd(0, 1'b0, 14'h00C8, 2'b00, 16'h0000);
        push_cmd(0, 1'b0, 14'h00CB, 2'b01, 16'hAAFF);
        push_cmd(1, 1'b0, 14'h00CB, 2'b00, 16'h0000);
        push_cmd(1, 1'b0, 14'h00CB, 2'b00, 16'h0000);
        exp_bus(0, 14'h00C8, 2'b00, 16'h0000, 0, 0);
        exp_bus(1, 14'h00CB, 2'b00, 16'h0000, 3, 0);
        exp_bus(0, 14'h00CB, 2'b01, 16'hAAFF, 3, 0);
        exp_bus(1, 14'h00CB, 2'b00, 16'h0000, 3, 0);
        exp_ack(0, 16'h1234, 16'h0000);
        exp_ack(1, 16'h1234, 16'h5678);
        exp_ack(0, 16'h1234, 16'h5678);
        exp_ack(1, 16'h1234, 16'h56FF);
        wait_idle(100, "interleave");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
